dual_port_ram_pipe: RTL and testbench

Parametrised true dual-port RAM, next generation of the team's asynchronous-read dual-port RAM.
- Adds registered and pipelined reads, byte-write enables and a selectable write-collision policy, including round-robin.
- Adds read-during-write selection, a saturating collision counter and a post-reset memory-clear sequencer.
- Used as shared buffer storage between two independent masters on one clock.

---
 rtl/dual_port_ram_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_dual_port_ram_pipe.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_pipe.sv
// dual_port_ram_pipe: true dual-port RAM, pipelined reads, byte lanes,
// collision policy, post-reset clear. Option macro: DPRAM_PARITY_EN
module dual_port_ram_pipe #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int BW = 8,
  parameter int RD_LAT = 1,
  parameter int PRIORITY = 0,
  parameter int RDW_MODE = 0,
  parameter int CLR_ON_RST = 1,
  localparam int NB = DW / BW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          initBusy,
  input  logic          aEn,
  input  logic          aWrite,
  input  logic [NB-1:0] aByteEn,
  input  logic [AW-1:0] aAddr,
  input  logic [DW-1:0] aWriteData,
  output logic [DW-1:0] aReadData,
  output logic          aReadValid,
  input  logic          bEn,
  input  logic          bWrite,
  input  logic [NB-1:0] bByteEn,
  input  logic [AW-1:0] bAddr,
  input  logic [DW-1:0] bWriteData,
  output logic [DW-1:0] bReadData,
  output logic          bReadValid,
  output logic          conflict,
  output logic [15:0]   conflictCount
`ifdef DPRAM_PARITY_EN
  ,
  output logic          aParityErr,
  output logic          bParityErr
`endif
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {INIT, RUN} state_t;

  state_t state, stateNext;
  logic [AW-1:0] clrAddr;
  logic [DW-1:0] mem [DEPTH];

  logic run, clrWe;
  logic aWr, bWr, aRd, bRd;
  logic sameAddr, collide, aWins, bWins, rrB;
  logic [NB-1:0] ov, aWe, bWe;
  logic [DW-1:0] aNew, bNew;

  logic aV1, aV2, bV1, bV2;
  logic [DW-1:0] aD1, aD2, bD1, bD2;

  // state register; reset picks clear or run
  always_ff @(posedge clk) begin
    if (rst) state <= (CLR_ON_RST != 0) ? INIT : RUN;
    else state <= stateNext;
  end

  // leave INIT once the last address is cleared
  always_comb begin
    stateNext = state;
    unique case (state)
      INIT: if (&clrAddr) stateNext = RUN;
      RUN:  stateNext = RUN;
    endcase
  end

  // clear address walks the array while in INIT
  always_ff @(posedge clk) begin
    if (rst) clrAddr <= '0;
    else if (state == INIT) clrAddr <= clrAddr + AW'(1);
  end

  assign initBusy = (state == INIT);
  assign run      = (state == RUN) && !rst;
  assign clrWe    = (state == INIT) && !rst;

  // request decode and overlapping-lane arbitration
  always_comb begin
    aWr = run && aEn && aWrite;
    bWr = run && bEn && bWrite;
    aRd = run && aEn && !aWrite;
    bRd = run && bEn && !bWrite;
    sameAddr = (aAddr == bAddr);
    ov = (aWr && bWr && sameAddr) ? (aByteEn & bByteEn) : '0;
    collide = |ov;
    aWins = (PRIORITY == 1) || (PRIORITY == 3 && !rrB);
    bWins = (PRIORITY == 2) || (PRIORITY == 3 && rrB);
    aWe = '0;
    bWe = '0;
    if (aWr) aWe = (aByteEn & ~ov) | (aWins ? ov : '0);
    if (bWr) bWe = (bByteEn & ~ov) | (bWins ? ov : '0);
  end

  assign conflict = collide && (PRIORITY == 0);

  // read word, optionally showing the other port's lanes
  always_comb begin
    aNew = mem[aAddr];
    bNew = mem[bAddr];
    for (int l = 0; l < NB; l++) begin
      if (RDW_MODE == 1 && sameAddr && bWe[l])
        aNew[l*BW +: BW] = bWriteData[l*BW +: BW];
      if (RDW_MODE == 1 && sameAddr && aWe[l])
        bNew[l*BW +: BW] = aWriteData[l*BW +: BW];
    end
  end

  // array writes: clear sequencer or arbitrated lanes
  always_ff @(posedge clk) begin
    if (clrWe) mem[clrAddr] <= '0;
    for (int l = 0; l < NB; l++) begin
      if (aWe[l])
        mem[aAddr][l*BW +: BW] <= aWriteData[l*BW +: BW];
      if (bWe[l])
        mem[bAddr][l*BW +: BW] <= bWriteData[l*BW +: BW];
    end
  end

  // collision counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      conflictCount <= '0;
      rrB <= 1'b0;
    end else if (collide) begin
      if (conflictCount != 16'hFFFF)
        conflictCount <= conflictCount + 16'd1;
      if (PRIORITY == 3) rrB <= !rrB;
    end
  end

  // port A read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      aV1 <= 1'b0;
      aV2 <= 1'b0;
      aReadValid <= 1'b0;
      aReadData <= '0;
    end else begin
      aV1 <= aRd;
      if (aRd) aD1 <= aNew;
      aV2 <= aV1;
      if (aV1) aD2 <= aD1;
      aReadValid <= (RD_LAT == 2) ? aV2 : aV1;
      if (RD_LAT == 2) begin
        if (aV2) aReadData <= aD2;
      end else if (aV1) begin
        aReadData <= aD1;
      end
    end
  end

  // port B read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      bV1 <= 1'b0;
      bV2 <= 1'b0;
      bReadValid <= 1'b0;
      bReadData <= '0;
    end else begin
      bV1 <= bRd;
      if (bRd) bD1 <= bNew;
      bV2 <= bV1;
      if (bV1) bD2 <= bD1;
      bReadValid <= (RD_LAT == 2) ? bV2 : bV1;
      if (RD_LAT == 2) begin
        if (bV2) bReadData <= bD2;
      end else if (bV1) begin
        bReadData <= bD1;
      end
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] aParNew, bParNew;
  logic aErr, bErr, aE1, aE2, bE1, bE2;

  function automatic logic [NB-1:0] lanePar(
    input logic [DW-1:0] d
  );
    logic [NB-1:0] p;
    p = '0;
    for (int l = 0; l < NB; l++) p[l] = ^d[l*BW +: BW];
    return p;
  endfunction

  // stored parity, merged exactly like the read word
  always_comb begin
    aParNew = par[aAddr];
    bParNew = par[bAddr];
    for (int l = 0; l < NB; l++) begin
      if (RDW_MODE == 1 && sameAddr && bWe[l])
        aParNew[l] = ^bWriteData[l*BW +: BW];
      if (RDW_MODE == 1 && sameAddr && aWe[l])
        bParNew[l] = ^aWriteData[l*BW +: BW];
    end
    aErr = |(aParNew ^ lanePar(aNew));
    bErr = |(bParNew ^ lanePar(bNew));
  end

  // parity array follows every clear and lane write
  always_ff @(posedge clk) begin
    if (clrWe) par[clrAddr] <= '0;
    for (int l = 0; l < NB; l++) begin
      if (aWe[l]) par[aAddr][l] <= ^aWriteData[l*BW +: BW];
      if (bWe[l]) par[bAddr][l] <= ^bWriteData[l*BW +: BW];
    end
  end

  // error flag travels alongside its read
  always_ff @(posedge clk) begin
    if (rst) begin
      aE1 <= 1'b0;
      aE2 <= 1'b0;
      bE1 <= 1'b0;
      bE2 <= 1'b0;
      aParityErr <= 1'b0;
      bParityErr <= 1'b0;
    end else begin
      aE1 <= aErr;
      aE2 <= aE1;
      bE1 <= bErr;
      bE2 <= bE1;
      aParityErr <= (RD_LAT == 2) ? (aV2 && aE2) : (aV1 && aE1);
      bParityErr <= (RD_LAT == 2) ? (bV2 && bE2) : (bV1 && bE1);
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// tb_dual_port_ram_pipe: four configurations driven in lockstep,
// checked against a word-level reference model.
`timescale 1ns/1ps
module tb_dual_port_ram_pipe;

  localparam int NI = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic aEn, aWrite, bEn, bWrite;
  logic [3:0] aBe, bBe;
  logic [AW-1:0] aAddr, bAddr;
  logic [31:0] aWd, bWd;

  logic [NI-1:0] busy, aVal, bVal, conf;
  logic [NI-1:0][31:0] aRdat, bRdat;
  logic [NI-1:0][15:0] cnt;

  for (genvar g = 0; g < NI; g++) begin : gi
    dual_port_ram_pipe #(
      .AW(AW), .DW(32), .BW(8),
      .RD_LAT((g == 1 || g == 2) ? 2 : 1),
      .PRIORITY(g),
      .RDW_MODE(g % 2),
      .CLR_ON_RST(1)
    ) dut (
      .clk(clk), .rst(rst), .initBusy(busy[g]),
      .aEn(aEn), .aWrite(aWrite), .aByteEn(aBe),
      .aAddr(aAddr), .aWriteData(aWd),
      .aReadData(aRdat[g]), .aReadValid(aVal[g]),
      .bEn(bEn), .bWrite(bWrite), .bByteEn(bBe),
      .bAddr(bAddr), .bWriteData(bWd),
      .bReadData(bRdat[g]), .bReadValid(bVal[g]),
      .conflict(conf[g]), .conflictCount(cnt[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic int latOf(int i);
    return (i == 1 || i == 2) ? 2 : 1;
  endfunction

  // reference model state
  typedef struct packed {
    int inst;
    int port;
    int due;
    logic [31:0] d;
  } rd_t;

  logic [31:0] mm [NI][DEPTH];
  int mcnt [NI];
  bit rr [NI];
  int busyLeft = 0;
  int cyc = 0;
  rd_t rq[$];
  logic [NI-1:0] eAV, eBV, eConf, confObs;
  logic [NI-1:0][31:0] eAD, eBD;

  task automatic idle();
    aEn = 0; aWrite = 0; aBe = '0; aAddr = '0; aWd = '0;
    bEn = 0; bWrite = 0; bBe = '0; bAddr = '0; bWd = '0;
  endtask

  // one clock: sample conflict, update the model, advance
  task automatic step();
    logic [31:0] oldA, oldB;
    logic [3:0] ov;
    bit aw, bw;
    rd_t keep[$];
    #2;
    confObs = conf;
    eConf = '0;
    if (rst) begin
      busyLeft = DEPTH;
      rq.delete();
      for (int i = 0; i < NI; i++) begin
        mcnt[i] = 0;
        rr[i] = 0;
        for (int a = 0; a < DEPTH; a++) mm[i][a] = '0;
      end
    end else if (busyLeft > 0) begin
      busyLeft--;
    end else begin
      aw = aEn && aWrite;
      bw = bEn && bWrite;
      for (int i = 0; i < NI; i++) begin
        oldA = mm[i][aAddr];
        oldB = mm[i][bAddr];
        ov = (aw && bw && aAddr == bAddr) ? (aBe & bBe) : 4'h0;
        for (int l = 0; l < 4; l++) begin
          if (!ov[l]) begin
            if (aw && aBe[l]) mm[i][aAddr][8*l +: 8] = aWd[8*l +: 8];
            if (bw && bBe[l]) mm[i][bAddr][8*l +: 8] = bWd[8*l +: 8];
          end else if (i == 1 || (i == 3 && !rr[i])) begin
            mm[i][aAddr][8*l +: 8] = aWd[8*l +: 8];
          end else if (i == 2 || (i == 3 && rr[i])) begin
            mm[i][bAddr][8*l +: 8] = bWd[8*l +: 8];
          end
        end
        if (ov != 4'h0) begin
          if (mcnt[i] < 65535) mcnt[i]++;
          if (i == 3) rr[i] = !rr[i];
          eConf[i] = (i == 0);
        end
        if (aEn && !aWrite)
          rq.push_back('{i, 0, cyc + 1 + latOf(i),
                         (i % 2 == 1) ? mm[i][aAddr] : oldA});
        if (bEn && !bWrite)
          rq.push_back('{i, 1, cyc + 1 + latOf(i),
                         (i % 2 == 1) ? mm[i][bAddr] : oldB});
      end
    end
    @(posedge clk);
    cyc++;
    eAV = '0;
    eBV = '0;
    if (rst) begin
      eAD = '0;
      eBD = '0;
    end
    foreach (rq[k]) begin
      if (rq[k].due == cyc) begin
        if (rq[k].port == 0) begin
          eAV[rq[k].inst] = 1'b1;
          eAD[rq[k].inst] = rq[k].d;
        end else begin
          eBV[rq[k].inst] = 1'b1;
          eBD[rq[k].inst] = rq[k].d;
        end
      end else if (rq[k].due > cyc) begin
        keep.push_back(rq[k]);
      end
    end
    rq = keep;
    @(negedge clk);
  endtask

  // issue one read on port p, optionally with the other port writing
  task automatic read_port(input int p, input logic [3:0] addr,
                           input bit wrOther, input logic [31:0] wd,
                           output logic [NI-1:0][31:0] d,
                           output logic [NI-1:0] seen);
    idle();
    if (p == 0) begin
      aEn = 1; aAddr = addr;
      if (wrOther) begin
        bEn = 1; bWrite = 1; bBe = 4'hF; bAddr = addr; bWd = wd;
      end
    end else begin
      bEn = 1; bAddr = addr;
      if (wrOther) begin
        aEn = 1; aWrite = 1; aBe = 4'hF; aAddr = addr; aWd = wd;
      end
    end
    seen = '0;
    d = '0;
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        if (p == 0 && aVal[i]) begin seen[i] = 1; d[i] = aRdat[i]; end
        if (p == 1 && bVal[i]) begin seen[i] = 1; d[i] = bRdat[i]; end
      end
    end
  endtask

  task automatic write_a(input logic [3:0] be, input logic [3:0] addr,
                         input logic [31:0] wd);
    idle();
    aEn = 1; aWrite = 1; aBe = be; aAddr = addr; aWd = wd;
    step();
    idle();
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (busy[0] !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL init_timeout: initBusy=%b after %0d cycles, want 0",
               busy[0], n);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (busy[i] !== 1'b1 || aVal[i] !== 1'b0 || bVal[i] !== 1'b0 ||
          aRdat[i] !== '0 || bRdat[i] !== '0 || cnt[i] !== '0 ||
          confObs[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: busy=%b av=%b bv=%b ad=%h bd=%h cnt=%h c=%b, want 1 0 0 0 0 0 0",
                 i, busy[i], aVal[i], bVal[i], aRdat[i], bRdat[i],
                 cnt[i], confObs[i]);
      end
    end
    rst = 0;
  endtask

  task automatic test_init();
    int n;
    logic [NI-1:0][31:0] d;
    logic [NI-1:0] seen;
    for (int k = 0; k < 5; k++) step();
    rst = 1;
    step();
    rst = 0;
    idle();
    aEn = 1; aAddr = 4'd5;
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin
      n++;
      step();
      idle();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (aVal[i] !== 1'b0 && busy[i] === 1'b1) begin
          miscompares++;
          $display("FAIL init_read[%0d]: aReadValid=%b during INIT, want 0",
                   i, aVal[i]);
        end
      end
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL init_len: initBusy high %0d cycles, want 16", n);
    end
    read_port(0, 4'd5, 0, '0, d, seen);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (seen[i] !== 1'b1 || d[i] !== 32'h0) begin
        miscompares++;
        $display("FAIL init_clear[%0d]: seen=%b data=%h, want 1 00000000",
                 i, seen[i], d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] mask [NI];
    logic [5:0] want;
    write_a(4'hF, 4'hA, 32'hDEADBEEF);
    for (int i = 0; i < NI; i++) mask[i] = '0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 3) begin aEn = 1; aAddr = 4'hA; end
      step();
      for (int i = 0; i < NI; i++) begin
        mask[i][k] = aVal[i];
        if (aVal[i]) begin
          vectors++;
          if (aRdat[i] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL b2b_data[%0d]: got %h, want deadbeef",
                     i, aRdat[i]);
          end
        end
      end
    end
    idle();
    for (int i = 0; i < NI; i++) begin
      want = (latOf(i) == 2) ? 6'b011100 : 6'b001110;
      vectors++;
      if (mask[i] !== want) begin
        miscompares++;
        $display("FAIL b2b_valid[%0d]: pattern %b, want %b",
                 i, mask[i], want);
      end
    end
  endtask

  task automatic test_byte_en();
    logic [NI-1:0][31:0] d;
    logic [NI-1:0] seen;
    write_a(4'hF, 4'd2, 32'h11223344);
    write_a(4'b0101, 4'd2, 32'hAABBCCDD);
    write_a(4'h0, 4'd2, 32'h99999999);
    read_port(0, 4'd2, 0, '0, d, seen);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (seen[i] !== 1'b1 || d[i] !== 32'h11BB33DD) begin
        miscompares++;
        $display("FAIL byte_en[%0d]: seen=%b data=%h, want 1 11bb33dd",
                 i, seen[i], d[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic [NI-1:0][31:0] d;
    logic [NI-1:0] seen;
    logic [31:0] exp1 [NI];
    logic [31:0] exp2 [NI];
    logic [31:0] exp3 [NI];
    logic [15:0] base [NI];
    exp1 = '{32'h0, 32'h1, 32'h2, 32'h1};
    exp2 = '{32'h0, 32'h1, 32'h2, 32'h2};
    exp3 = '{32'h00FF00FF, 32'h00FFFFFF, 32'h00FF00FF, 32'h00FFFFFF};
    for (int i = 0; i < NI; i++) base[i] = cnt[i];
    for (int r = 0; r < 3; r++) begin
      idle();
      aEn = 1; aWrite = 1; bEn = 1; bWrite = 1;
      if (r < 2) begin
        aBe = 4'hF; bBe = 4'hF; aAddr = 4'd7; bAddr = 4'd7;
        aWd = 32'h1; bWd = 32'h2;
      end else begin
        aBe = 4'b0011; bBe = 4'b0110; aAddr = 4'd3; bAddr = 4'd3;
        aWd = 32'h0000FFFF; bWd = 32'hFFFF0000;
      end
      step();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (confObs[i] !== (i == 0)) begin
          miscompares++;
          $display("FAIL coll_flag[%0d] r%0d: conflict=%b, want %b",
                   i, r, confObs[i], (i == 0));
        end
      end
      read_port(0, (r < 2) ? 4'd7 : 4'd3, 0, '0, d, seen);
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (seen[i] !== 1'b1 ||
            d[i] !== ((r == 0) ? exp1[i] : (r == 1) ? exp2[i] : exp3[i]))
        begin
          miscompares++;
          $display("FAIL coll_data[%0d] r%0d: seen=%b data=%h, want %h",
                   i, r, seen[i], d[i],
                   (r == 0) ? exp1[i] : (r == 1) ? exp2[i] : exp3[i]);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (cnt[i] !== base[i] + 16'd3) begin
        miscompares++;
        $display("FAIL coll_count[%0d]: count=%0d, want %0d",
                 i, cnt[i], base[i] + 16'd3);
      end
    end
    idle();
    aEn = 1; aWrite = 1; bEn = 1; bWrite = 1;
    aBe = 4'b0011; bBe = 4'b1100; aAddr = 4'd4; bAddr = 4'd4;
    step();
    idle();
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (confObs[i] !== 1'b0 || cnt[i] !== base[i] + 16'd3) begin
        miscompares++;
        $display("FAIL disjoint[%0d]: conflict=%b count=%0d, want 0 %0d",
                 i, confObs[i], cnt[i], base[i] + 16'd3);
      end
    end
  endtask

  task automatic test_rdw();
    logic [NI-1:0][31:0] d;
    logic [NI-1:0] seen;
    write_a(4'hF, 4'd9, 32'h5);
    read_port(0, 4'd9, 1, 32'h9, d, seen);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (seen[i] !== 1'b1 || d[i] !== ((i % 2 == 1) ? 32'h9 : 32'h5)) begin
        miscompares++;
        $display("FAIL rdw_a[%0d]: seen=%b data=%h, want %h",
                 i, seen[i], d[i], (i % 2 == 1) ? 32'h9 : 32'h5);
      end
    end
    read_port(1, 4'd9, 1, 32'h7, d, seen);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (seen[i] !== 1'b1 || d[i] !== ((i % 2 == 1) ? 32'h7 : 32'h9)) begin
        miscompares++;
        $display("FAIL rdw_b[%0d]: seen=%b data=%h, want %h",
                 i, seen[i], d[i], (i % 2 == 1) ? 32'h7 : 32'h9);
      end
    end
    idle();
    aEn = 1; aAddr = 4'd9;
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (aVal[i] !== 1'b0 || aRdat[i] !== 32'h0) begin
          miscompares++;
          $display("FAIL rst_flight[%0d]: valid=%b data=%h, want 0 0",
                   i, aVal[i], aRdat[i]);
        end
      end
      step();
    end
    wait_init();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = (n == 250);
      aEn = ($urandom_range(3) != 0);
      aWrite = $urandom_range(1);
      aBe = 4'($urandom);
      aAddr = 4'($urandom_range(3));
      aWd = $urandom;
      bEn = ($urandom_range(3) != 0);
      bWrite = $urandom_range(1);
      bBe = 4'($urandom);
      bAddr = 4'($urandom_range(3));
      bWd = $urandom;
      step();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (aVal[i] !== eAV[i] || aRdat[i] !== eAD[i] ||
            bVal[i] !== eBV[i] || bRdat[i] !== eBD[i]) begin
          miscompares++;
          $display("FAIL rand_rd[%0d] n%0d: a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                   i, n, aVal[i], aRdat[i], bVal[i], bRdat[i],
                   eAV[i], eAD[i], eBV[i], eBD[i]);
        end
        vectors++;
        if (confObs[i] !== eConf[i] || cnt[i] !== 16'(mcnt[i]) ||
            busy[i] !== (busyLeft > 0)) begin
          miscompares++;
          $display("FAIL rand_ctl[%0d] n%0d: c=%b cnt=%0d busy=%b, want %b %0d %b",
                   i, n, confObs[i], cnt[i], busy[i],
                   eConf[i], mcnt[i], (busyLeft > 0));
        end
      end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_init();
    test_back_to_back();
    test_byte_en();
    test_collision();
    test_rdw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
